itlb_miss_handler: RTL and testbench
====================================

ITLB_MISS_HANDLER -- requirements
Module: itlb_miss_handler

Interface
REQ-001 SHALL provide parameter VIRT_ADDR_WIDTH, default 32, virtual address width.
REQ-002 SHALL provide parameter PHY_ADDR_WIDTH, default 20, physical address width.
REQ-003 SHALL provide parameter PAGE_SIZE, default 12, page-offset width in bits.
REQ-004 SHALL provide parameter PHY_PAGE_NUM_WIDTH, default 8, physical page number (PPN) width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 tlb_miss  input  1  iTLB miss indication for the current fetch.
REQ-008 VirtualAddr  input  VIRT_ADDR_WIDTH  faulting fetch virtual address.
REQ-009 ptbr  input  PHY_ADDR_WIDTH  page-table base physical address.
REQ-010 mem_req  output  1  page-table read request.
REQ-011 mem_addr  output  PHY_ADDR_WIDTH  page-table entry (PTE) address.
REQ-012 mem_ready  input  1  memory read data valid / request accepted.
REQ-013 mem_rdata  input  32  PTE; bit 31 = valid, bits [PHY_PAGE_NUM_WIDTH-1:0] = PPN.
REQ-014 tlb_write  output  1  one-cycle iTLB fill strobe.
REQ-015 physical_page_num_mem  output  PHY_PAGE_NUM_WIDTH  PPN delivered to the iTLB.
REQ-016 stall_fetch  output  1  freeze the fetch stage while a walk is in progress.
REQ-017 page_fault  output  1  one-cycle fault strobe for an invalid PTE.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT, FILL, FAULT.
REQ-019 IDLE: on tlb_miss=1, latch VPN = VirtualAddr[VIRT_ADDR_WIDTH-1:PAGE_SIZE] and ptbr, then go to REQ next cycle.
REQ-020 mem_addr SHALL equal (latched ptbr + {VPN,2'b00}) modulo 2^PHY_ADDR_WIDTH; wrap-around is silent.
REQ-021 REQ: assert mem_req with stable mem_addr, then go to WAIT.
REQ-022 WAIT: hold mem_req=1 and mem_addr stable until mem_ready=1; there is no timeout.
REQ-023 On mem_ready=1 in WAIT: if mem_rdata[31]=1, capture the PPN and go to FILL; otherwise go to FAULT; mem_req drops the following cycle.
REQ-024 FILL: tlb_write=1 for exactly one cycle with physical_page_num_mem = captured PPN, then return to IDLE.
REQ-025 FAULT: page_fault=1 for exactly one cycle, no tlb_write, then return to IDLE.
REQ-026 stall_fetch SHALL be 1 in REQ, WAIT, FILL and FAULT, and also combinationally in IDLE when tlb_miss=1; otherwise 0.
REQ-027 tlb_miss asserted in any state other than IDLE SHALL be ignored; no walk is queued.
REQ-028 mem_ready asserted outside WAIT SHALL be ignored.
REQ-029 VirtualAddr/ptbr changes after latching SHALL NOT affect the walk in progress.
REQ-030 Miss-to-fill latency with zero-wait memory (mem_ready=1 on the first WAIT cycle) SHALL be 4 cycles from the latching edge: REQ, WAIT, FILL, IDLE.
REQ-031 physical_page_num_mem SHALL hold its last value outside FILL.

Reset
REQ-032 On reset=0 at a rising edge: state=IDLE, mem_req=0, tlb_write=0, page_fault=0, physical_page_num_mem=0, latched VPN/ptbr=0, mem_addr=0.
REQ-033 Reset mid-walk SHALL abort the walk with no tlb_write or page_fault; a subsequent late mem_ready is ignored.

Structure
REQ-034 Width constants (VIRT_ADDR_WIDTH, PHY_ADDR_WIDTH, PAGE_SIZE, PHY_PAGE_NUM_WIDTH), the PTE valid-bit index and the FSM state encodings SHALL live in the shared definitions header/package used by iTLB.
REQ-035 SHALL be a single module with no sub-modules; the FSM and datapath are small enough to stay flat.

Verification
REQ-036 Hit path: ptbr=0x01000, VirtualAddr=0x00003ABC, tlb_miss=1 -> mem_addr=0x0100C; mem_ready=1 with mem_rdata=0x8000_0042 -> single tlb_write with PPN=0x42; stall_fetch high throughout.
REQ-037 Fault path: mem_rdata=0x0000_0042 -> single page_fault pulse, tlb_write stays 0, FSM back in IDLE.
REQ-038 Wait states: mem_ready held low for 5 cycles -> mem_req and mem_addr stable all 5 cycles; fill occurs on the cycle after mem_ready.
REQ-039 Wrap: ptbr=0xFFFFC, VPN=0x00002 -> mem_addr=0x00004.
REQ-040 Reset in WAIT, then mem_ready=1 after reset release -> no tlb_write, no page_fault, mem_req=0, state IDLE.
REQ-041 Second tlb_miss and changed VirtualAddr during WAIT -> ignored; only the original PPN is written, exactly once.

Source files
------------

// File: rtl/itlb_miss_handler_pkg.sv
// Shared iTLB definitions: default address/page widths, PTE layout and
// the encodings of the miss-handler page-walk FSM.
package itlb_miss_handler_pkg;

  localparam int VIRT_ADDR_WIDTH_DEF    = 32;
  localparam int PHY_ADDR_WIDTH_DEF     = 20;
  localparam int PAGE_SIZE_DEF          = 12;
  localparam int PHY_PAGE_NUM_WIDTH_DEF = 8;

  // A PTE is one 32-bit word, so the table index is the VPN scaled by 4.
  localparam int PTE_WIDTH       = 32;
  localparam int PTE_VALID_BIT   = 31;
  localparam int PTE_ENTRY_SHIFT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FILL  = 3'd3,
    ST_FAULT = 3'd4
  } walk_state_e;

  function automatic logic pte_valid(input logic [PTE_WIDTH-1:0] pte);
    return pte[PTE_VALID_BIT];
  endfunction

endpackage

// File: rtl/itlb_miss_handler.sv
// Single-level iTLB page walker: on a fetch miss it reads one PTE and either
// fills the iTLB with the PPN or raises a one-cycle page fault.
module itlb_miss_handler
  import itlb_miss_handler_pkg::*;
#(
  parameter int VIRT_ADDR_WIDTH    = VIRT_ADDR_WIDTH_DEF,
  parameter int PHY_ADDR_WIDTH     = PHY_ADDR_WIDTH_DEF,
  parameter int PAGE_SIZE          = PAGE_SIZE_DEF,
  parameter int PHY_PAGE_NUM_WIDTH = PHY_PAGE_NUM_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tlb_miss,
  input  logic [VIRT_ADDR_WIDTH-1:0]    VirtualAddr,
  input  logic [PHY_ADDR_WIDTH-1:0]     ptbr,
  output logic                          mem_req,
  output logic [PHY_ADDR_WIDTH-1:0]     mem_addr,
  input  logic                          mem_ready,
  input  logic [PTE_WIDTH-1:0]          mem_rdata,
  output logic                          tlb_write,
  output logic [PHY_PAGE_NUM_WIDTH-1:0] physical_page_num_mem,
  output logic                          stall_fetch,
  output logic                          page_fault
);

  localparam int VPN_WIDTH = VIRT_ADDR_WIDTH - PAGE_SIZE;
  localparam int OFS_WIDTH = VPN_WIDTH + PTE_ENTRY_SHIFT;
  localparam int SUM_WIDTH = (OFS_WIDTH > PHY_ADDR_WIDTH) ? OFS_WIDTH : PHY_ADDR_WIDTH;

  walk_state_e                   state_q, state_d;
  logic [VPN_WIDTH-1:0]          vpn_q, vpn_d;
  logic [PHY_ADDR_WIDTH-1:0]     ptbr_q, ptbr_d;
  logic [PHY_ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [PHY_PAGE_NUM_WIDTH-1:0] ppn_q, ppn_d;
  logic                          mem_req_q, mem_req_d;
  logic                          tlb_write_q, tlb_write_d;
  logic                          page_fault_q, page_fault_d;
  logic [SUM_WIDTH-1:0]          pte_sum;
  logic                          miss_accept;
  logic                          pte_resp;
  logic                          unused_ok;

  assign miss_accept = (state_q == ST_IDLE) && tlb_miss;
  assign pte_resp    = (state_q == ST_WAIT) && mem_ready;
  assign unused_ok   = ^{VirtualAddr[PAGE_SIZE-1:0], mem_rdata};

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; misses outside IDLE and ready outside WAIT are dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (tlb_miss) state_d = ST_REQ;
        else          state_d = ST_IDLE;
      end
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_ready) state_d = pte_valid(mem_rdata) ? ST_FILL : ST_FAULT;
        else           state_d = ST_WAIT;
      end
      ST_FILL:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: strobes are registered from the state being entered
  always_comb begin
    mem_req_d    = 1'b0;
    tlb_write_d  = 1'b0;
    page_fault_d = 1'b0;
    case (state_d)
      ST_REQ:   mem_req_d    = 1'b1;
      ST_WAIT:  mem_req_d    = 1'b1;
      ST_FILL:  tlb_write_d  = 1'b1;
      ST_FAULT: page_fault_d = 1'b1;
      default: begin
        mem_req_d    = 1'b0;
        tlb_write_d  = 1'b0;
        page_fault_d = 1'b0;
      end
    endcase
    stall_fetch = (state_q != ST_IDLE) || tlb_miss;
  end

  // Walk datapath: latch VPN/ptbr on accept; PTE address derives from the latched pair
  always_comb begin
    vpn_d  = vpn_q;
    ptbr_d = ptbr_q;
    if (miss_accept) begin
      vpn_d  = VirtualAddr[VIRT_ADDR_WIDTH-1:PAGE_SIZE];
      ptbr_d = ptbr;
    end else begin
      vpn_d  = vpn_q;
      ptbr_d = ptbr_q;
    end
    if (pte_resp && pte_valid(mem_rdata)) begin
      ppn_d = mem_rdata[PHY_PAGE_NUM_WIDTH-1:0];
    end else begin
      ppn_d = ppn_q;
    end
    pte_sum    = SUM_WIDTH'(ptbr_d) + SUM_WIDTH'({vpn_d, {PTE_ENTRY_SHIFT{1'b0}}});
    mem_addr_d = pte_sum[PHY_ADDR_WIDTH-1:0];
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      vpn_q        <= '0;
      ptbr_q       <= '0;
      mem_addr_q   <= '0;
      ppn_q        <= '0;
      mem_req_q    <= 1'b0;
      tlb_write_q  <= 1'b0;
      page_fault_q <= 1'b0;
    end else begin
      vpn_q        <= vpn_d;
      ptbr_q       <= ptbr_d;
      mem_addr_q   <= mem_addr_d;
      ppn_q        <= ppn_d;
      mem_req_q    <= mem_req_d;
      tlb_write_q  <= tlb_write_d;
      page_fault_q <= page_fault_d;
    end
  end

  assign mem_req               = mem_req_q;
  assign mem_addr              = mem_addr_q;
  assign tlb_write             = tlb_write_q;
  assign page_fault            = page_fault_q;
  assign physical_page_num_mem = ppn_q;

endmodule

// File: tb/tb_itlb_miss_handler.sv
// Randomised walk bench for itlb_miss_handler against a transaction-level model.
module tb_itlb_miss_handler;

  logic        clk = 1'b0;
  logic        reset;
  logic        tlb_miss;
  logic [31:0] VirtualAddr;
  logic [19:0] ptbr;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        tlb_write;
  logic [7:0]  ppn_out;
  logic        stall_fetch;
  logic        page_fault;

  int n_cmp = 0;
  int n_err = 0;
  int fill_seen = 0;
  int fault_seen = 0;
  int fill_exp = 0;
  int fault_exp = 0;
  logic [7:0] ppn_exp = 8'h00;

  itlb_miss_handler dut (
    .clk                   (clk),
    .reset                 (reset),
    .tlb_miss              (tlb_miss),
    .VirtualAddr           (VirtualAddr),
    .ptbr                  (ptbr),
    .mem_req               (mem_req),
    .mem_addr              (mem_addr),
    .mem_ready             (mem_ready),
    .mem_rdata             (mem_rdata),
    .tlb_write             (tlb_write),
    .physical_page_num_mem (ppn_out),
    .stall_fetch           (stall_fetch),
    .page_fault            (page_fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tlb_write === 1'b1)  fill_seen++;
    if (page_fault === 1'b1) fault_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_tlb_write"}, tlb_write, 0);
    chk({tag, "_page_fault"}, page_fault, 0);
    chk({tag, "_ppn"}, ppn_out, ppn_exp);
    chk({tag, "_stall"}, stall_fetch, 0);
  endtask

  // One complete walk; rst_at >= 0 resets during that WAIT cycle instead of finishing.
  task automatic walk(input logic [19:0] pt, input logic [31:0] va, input int wait_n,
                      input logic [31:0] pte, input int rst_at, input bit noise);
    longint     s;
    logic [19:0] exp_addr;
    bit         ok;
    s        = longint'(pt) + 4 * longint'(va >> 12);
    exp_addr = s[19:0];
    ok       = pte[31];

    ptbr = pt; VirtualAddr = va; tlb_miss = 1'b1;
    mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_rdata = $urandom;
    #1 chk("stall_on_miss", stall_fetch, 1);
    tick();
    chk("req_mem_req", mem_req, 1);
    chk("req_addr", mem_addr, exp_addr);
    chk("req_stall", stall_fetch, 1);
    chk("req_no_write", tlb_write, 0);
    if (noise) begin
      tlb_miss = 1'($urandom_range(0, 1)); VirtualAddr = $urandom; ptbr = 20'($urandom);
      mem_ready = 1'($urandom_range(0, 1));
    end else begin
      tlb_miss = 1'b0; mem_ready = 1'b0;
    end
    mem_rdata = $urandom;
    tick();
    for (int i = 0; i <= wait_n; i++) begin
      chk("wait_mem_req", mem_req, 1);
      chk("wait_addr", mem_addr, exp_addr);
      chk("wait_stall", stall_fetch, 1);
      chk("wait_no_write", tlb_write, 0);
      chk("wait_no_fault", page_fault, 0);
      if (i == rst_at) begin
        reset = 1'b0; tlb_miss = 1'b0; mem_ready = 1'b0;
        tick();
        ppn_exp = 8'h00;
        idle_checks("rst_mid");
        chk("rst_mid_addr", mem_addr, 0);
        reset = 1'b1; mem_ready = 1'b1; mem_rdata = {1'b1, 23'($urandom), 8'($urandom)};
        tick();
        idle_checks("late_ready");
        mem_ready = 1'b0;
        tick();
        idle_checks("after_rst");
        return;
      end
      if (noise) begin
        tlb_miss = 1'($urandom_range(0, 1)); VirtualAddr = $urandom; ptbr = 20'($urandom);
      end
      if (i == wait_n) begin
        mem_ready = 1'b1; mem_rdata = pte;
      end else begin
        mem_ready = 1'b0; mem_rdata = $urandom;
      end
      tick();
    end
    if (ok) begin
      ppn_exp = pte[7:0];
      fill_exp++;
    end else begin
      fault_exp++;
    end
    chk("done_tlb_write", tlb_write, ok);
    chk("done_page_fault", page_fault, !ok);
    chk("done_req_drop", mem_req, 0);
    chk("done_stall", stall_fetch, 1);
    chk("done_ppn", ppn_out, ppn_exp);
    tlb_miss = 1'b0;
    mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_rdata = $urandom;
    tick();
    mem_ready = 1'b0;
    idle_checks("back_idle");
  endtask

  initial begin
    reset = 1'b0; tlb_miss = 1'b0; mem_ready = 1'b0;
    VirtualAddr = 32'h0; ptbr = 20'h0; mem_rdata = 32'h0;
    tick();
    tick();
    idle_checks("reset");
    chk("reset_addr", mem_addr, 0);
    reset = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'h8000_00FF;
    tick();
    idle_checks("idle_ready_ignored");
    mem_ready = 1'b0;

    walk(20'h01000, 32'h0000_3ABC, 0, 32'h8000_0042, -1, 1'b0);
    walk(20'h01000, 32'h0000_3ABC, 0, 32'h0000_0042, -1, 1'b0);
    walk(20'h23450, 32'h1234_5678, 5, 32'h8000_0011, -1, 1'b0);
    walk(20'hFFFFC, 32'h0000_2000, 1, 32'h8000_00A5, -1, 1'b0);
    walk(20'h00400, 32'h0040_1000, 3, 32'h8000_0077, -1, 1'b1);
    walk(20'h00800, 32'h0000_5000, 2, 32'h8000_0033, 1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int w;
      int r;
      w = $urandom_range(0, 6);
      r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, w)) : -1;
      walk(20'($urandom), $urandom, w, {1'($urandom_range(0, 1)), 31'($urandom)}, r, 1'b1);
    end

    tick();
    chk("fill_count", fill_seen, fill_exp);
    chk("fault_count", fault_seen, fault_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
